// File: rtl/fill_pkg.sv
`default_nettype none
// fill_pkg: state, mode and warm-mix codes shared by the fill valve sequencer.
// Rev 1.0
package fill_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_DONE   = 3'd3,
      ST_FAULT  = 3'd4
   } fase_e;

   localparam logic [1:0] MODO_AMBIENTE = 2'b00;
   localparam logic [1:0] MODO_CALIENTE = 2'b01;
   localparam logic [1:0] MODO_TIBIA    = 2'b10;
   localparam logic [1:0] MODO_FRIA     = 2'b11;

   typedef enum logic [1:0] {
      MIX_H  = 2'd0,
      MIX_D1 = 2'd1,
      MIX_C  = 2'd2,
      MIX_D2 = 2'd3
   } mix_e;

   function automatic logic is_busy(input fase_e s);
      return (s == ST_FILL) || (s == ST_SETTLE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fill_valve_sequencer_level_confirm.sv
`default_nettype none
// level_confirm: synchronizes the tank-full sensor and accepts it after a run of highs.
// Rev 1.0
module level_confirm #(
   parameter int CNT_W         = 24,
   parameter int LEVEL_CONFIRM = 4
) (
   input  logic clk,
   input  logic iReset_Temperatura,
   input  logic level,
   output logic full
);

   localparam logic [CNT_W-1:0] CONFIRM = CNT_W'(LEVEL_CONFIRM);

   logic             sync_a;
   logic             sync_b;
   logic [CNT_W-1:0] run_cnt;

   always_ff @(posedge clk or negedge iReset_Temperatura) begin
      if (!iReset_Temperatura) begin
         sync_a  <= 1'b0;
         sync_b  <= 1'b0;
         run_cnt <= '0;
      end else begin
         sync_a <= level;
         sync_b <= sync_a;
         // any low synchronized sample restarts the run; the count parks at CONFIRM
         if (!sync_b) begin
            run_cnt <= '0;
         end else if (run_cnt != CONFIRM) begin
            run_cnt <= run_cnt + CNT_W'(1);
         end
      end
   end

   assign full = (run_cnt == CONFIRM);

endmodule
`default_nettype wire

// File: rtl/fill_valve_sequencer.sv
`default_nettype none
// fill_valve_sequencer: drives hot/cold valves for one tank fill at the selected temperature.
// Rev 1.0
module fill_valve_sequencer
   import fill_pkg::*;
#(
   parameter int               CNT_W         = 24,
   parameter logic [CNT_W-1:0] FILL_TIMEOUT  = 24'd5_000_000,
   parameter int               MIX_HOT       = 16,
   parameter int               MIX_COLD      = 16,
   parameter int               DEAD          = 2,
   parameter int               LEVEL_CONFIRM = 4,
   parameter int               SETTLE        = 16
) (
   input  logic       clk,
   input  logic       iReset_Temperatura,
   input  logic [1:0] iEstado_Temp,
   input  logic       iStart,
   input  logic       iAbort,
   input  logic       iNivel_Lleno,
   output logic       oValvula_Fria,
   output logic       oValvula_Caliente,
   output logic       oBusy,
   output logic       oDone,
   output logic       oFalla,
   output logic [2:0] oFase
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = FILL_TIMEOUT - CNT_W'(1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] HOT_LAST     = CNT_W'(MIX_HOT - 1);
   localparam logic [CNT_W-1:0] COLD_LAST    = CNT_W'(MIX_COLD - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEAD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   fase_e            state;
   fase_e            state_nxt;
   logic [1:0]       modo;
   logic [1:0]       modo_nxt;
   mix_e             mix_phase;
   mix_e             mix_phase_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] mix_cnt;
   logic [CNT_W-1:0] mix_cnt_nxt;
   logic [CNT_W-1:0] mix_last;
   logic             full;
   logic             caliente_nxt;
   logic             fria_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             falla_nxt;

   level_confirm #(
      .CNT_W         (CNT_W),
      .LEVEL_CONFIRM (LEVEL_CONFIRM)
   ) u_level (
      .clk                (clk),
      .iReset_Temperatura (iReset_Temperatura),
      .level              (iNivel_Lleno),
      .full               (full)
   );

   // State, datapath and registered outputs all move on the same edge.
   always_ff @(posedge clk or negedge iReset_Temperatura) begin
      if (!iReset_Temperatura) begin
         state             <= ST_IDLE;
         modo              <= MODO_AMBIENTE;
         cnt               <= '0;
         mix_phase         <= MIX_H;
         mix_cnt           <= '0;
         oValvula_Fria     <= 1'b0;
         oValvula_Caliente <= 1'b0;
         oBusy             <= 1'b0;
         oDone             <= 1'b0;
         oFalla            <= 1'b0;
         oFase             <= 3'd0;
      end else begin
         state             <= state_nxt;
         modo              <= modo_nxt;
         cnt               <= cnt_nxt;
         mix_phase         <= mix_phase_nxt;
         mix_cnt           <= mix_cnt_nxt;
         oValvula_Fria     <= fria_nxt;
         oValvula_Caliente <= caliente_nxt;
         oBusy             <= busy_nxt;
         oDone             <= done_nxt;
         oFalla            <= falla_nxt;
         oFase             <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      modo_nxt      = modo;
      cnt_nxt       = '0;
      mix_phase_nxt = MIX_H;
      mix_cnt_nxt   = '0;

      case (mix_phase)
         MIX_H:   mix_last = HOT_LAST;
         MIX_C:   mix_last = COLD_LAST;
         default: mix_last = DEAD_LAST;
      endcase

      if (iAbort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (iStart) begin
                  state_nxt = ST_FILL;
                  modo_nxt  = iEstado_Temp;
               end
            end
            ST_FILL: begin
               // a confirmed level wins over a timeout on the same cycle
               if (full) begin
                  state_nxt = ST_SETTLE;
               end else if (cnt == TIMEOUT_LAST) begin
                  state_nxt = ST_FAULT;
               end
            end
            ST_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  state_nxt = ST_DONE;
               end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_IDLE;
         endcase
      end

      // phase counter restarts on every state change and saturates
      if (state_nxt == state && is_busy(state)) begin
         cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      end

      // warm mix only advances while remaining in FILL; any exit or entry restarts at HOT
      if (state == ST_FILL && state_nxt == ST_FILL && modo == MODO_TIBIA) begin
         mix_phase_nxt = mix_phase;
         if (mix_cnt >= mix_last) begin
            case (mix_phase)
               MIX_H:   mix_phase_nxt = MIX_D1;
               MIX_D1:  mix_phase_nxt = MIX_C;
               MIX_C:   mix_phase_nxt = MIX_D2;
               default: mix_phase_nxt = MIX_H;
            endcase
         end else begin
            mix_cnt_nxt = mix_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      caliente_nxt = 1'b0;
      fria_nxt     = 1'b0;
      if (state_nxt == ST_FILL) begin
         case (modo_nxt)
            MODO_AMBIENTE: begin
               caliente_nxt = 1'b1;
               fria_nxt     = 1'b1;
            end
            MODO_CALIENTE: caliente_nxt = 1'b1;
            MODO_FRIA:     fria_nxt     = 1'b1;
            default: begin
               caliente_nxt = (mix_phase_nxt == MIX_H);
               fria_nxt     = (mix_phase_nxt == MIX_C);
            end
         endcase
      end
      busy_nxt  = is_busy(state_nxt);
      done_nxt  = (state_nxt == ST_DONE);
      falla_nxt = (state_nxt == ST_FAULT);
   end

endmodule
`default_nettype wire

// File: tb/tb_fill_valve_sequencer.sv
`default_nettype none
// tb_fill_valve_sequencer: directed stimulus with a cycle-stamped expectation scoreboard.
// Rev 1.0
module tb_fill_valve_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] estado;
   logic       start;
   logic       abort;
   logic       nivel;
   logic       fria;
   logic       caliente;
   logic       busy;
   logic       done;
   logic       falla;
   logic [2:0] fase;

   typedef struct {
      int         cyc;
      string      name;
      logic [7:0] want;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc       = 0;
   int   t0        = 0;
   int   checks    = 0;
   int   errors    = 0;
   logic warm_chk  = 1'b0;

   fill_valve_sequencer #(
      .CNT_W         (24),
      .FILL_TIMEOUT  (24'd50),
      .MIX_HOT       (3),
      .MIX_COLD      (2),
      .DEAD          (1),
      .LEVEL_CONFIRM (2),
      .SETTLE        (4)
   ) dut (
      .clk                (clk),
      .iReset_Temperatura (rst_n),
      .iEstado_Temp       (estado),
      .iStart             (start),
      .iAbort             (abort),
      .iNivel_Lleno       (nivel),
      .oValvula_Fria      (fria),
      .oValvula_Caliente  (caliente),
      .oBusy              (busy),
      .oDone              (done),
      .oFalla             (falla),
      .oFase              (fase)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic exp_at(input int rel, input string nm, input logic [2:0] f,
                         input logic c, input logic fr, input logic b,
                         input logic d, input logic fl);
      exp_t x;
      x.cyc  = t0 + rel;
      x.name = nm;
      x.want = {f, c, fr, b, d, fl};
      sb.push_back(x);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // start is seen on the next edge, which becomes relative cycle 0
   task automatic start_fill(input logic [1:0] m);
      estado = m;
      start  = 1'b1;
      t0     = cyc + 1;
      step(1);
      start  = 1'b0;
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: cycle %0d passed unsampled (now %0d)", e.name, e.cyc, cyc);
      end
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         checks++;
         if ({fase, caliente, fria, busy, done, falla} !== e.want) begin
            errors++;
            $display("FAIL %s @%0d: got fase=%0d cal=%b fria=%b busy=%b done=%b falla=%b, want fase=%0d cal=%b fria=%b busy=%b done=%b falla=%b",
                     e.name, cyc, fase, caliente, fria, busy, done, falla,
                     e.want[7:5], e.want[4], e.want[3], e.want[2], e.want[1], e.want[0]);
         end
      end
      if (warm_chk) begin
         checks++;
         if (caliente && fria) begin
            errors++;
            $display("FAIL warm_overlap @%0d: got cal=%b fria=%b, want never both 1", cyc, caliente, fria);
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      estado = 2'b00;
      start  = 1'b0;
      abort  = 1'b0;
      nivel  = 1'b0;
      exp_at(1, "reset", 3'd0, 0, 0, 0, 0, 0);
      exp_at(2, "reset_hold", 3'd0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step(2);

      // hot fill ended by level raised at cycle 10
      start_fill(2'b01);
      exp_at(0,  "t1_fill_start", 3'd1, 1, 0, 1, 0, 0);
      exp_at(5,  "t1_fill_mid",   3'd1, 1, 0, 1, 0, 0);
      exp_at(13, "t1_fill_last",  3'd1, 1, 0, 1, 0, 0);
      exp_at(14, "t1_settle",     3'd2, 0, 0, 1, 0, 0);
      exp_at(17, "t1_settle_end", 3'd2, 0, 0, 1, 0, 0);
      exp_at(18, "t1_done",       3'd3, 0, 0, 0, 1, 0);
      exp_at(19, "t1_idle",       3'd0, 0, 0, 0, 0, 0);
      step(9);
      nivel = 1'b1;
      step(10);
      nivel = 1'b0;
      step(4);

      // warm mix: H,H,H,0,F,F,0 repeating, then abort
      start_fill(2'b10);
      warm_chk = 1'b1;
      for (int r = 0; r <= 20; r++) begin
         int p;
         p = r % 7;
         exp_at(r, "t2_mix", 3'd1, (p < 3), (p == 4 || p == 5), 1, 0, 0);
      end
      exp_at(21, "t2_abort", 3'd0, 0, 0, 0, 0, 0);
      step(20);
      abort = 1'b1;
      step(1);
      abort    = 1'b0;
      warm_chk = 1'b0;
      step(2);

      // cold fill times out; start ignored in fault; abort clears
      start_fill(2'b11);
      exp_at(0,  "t3_fill",          3'd1, 0, 1, 1, 0, 0);
      exp_at(49, "t3_fill_last",     3'd1, 0, 1, 1, 0, 0);
      exp_at(50, "t3_fault",         3'd4, 0, 0, 0, 0, 1);
      exp_at(56, "t3_start_ignored", 3'd4, 0, 0, 0, 0, 1);
      exp_at(60, "t3_abort_clear",   3'd0, 0, 0, 0, 0, 0);
      step(54);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(4);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      step(2);

      // ambient fill ignores mode change and restart request
      start_fill(2'b00);
      exp_at(0,  "t4_fill",     3'd1, 1, 1, 1, 0, 0);
      exp_at(4,  "t4_restart",  3'd1, 1, 1, 1, 0, 0);
      exp_at(6,  "t4_no_relat", 3'd1, 1, 1, 1, 0, 0);
      exp_at(9,  "t4_steady",   3'd1, 1, 1, 1, 0, 0);
      exp_at(10, "t4_abort",    3'd0, 0, 0, 0, 0, 0);
      step(3);
      estado = 2'b01;
      start  = 1'b1;
      step(2);
      start = 1'b0;
      step(4);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      step(2);

      // single-cycle level glitch must not close the valves
      start_fill(2'b01);
      exp_at(7,  "t5_glitch_a",  3'd1, 1, 0, 1, 0, 0);
      exp_at(8,  "t5_glitch_b",  3'd1, 1, 0, 1, 0, 0);
      exp_at(10, "t5_glitch_c",  3'd1, 1, 0, 1, 0, 0);
      exp_at(15, "t5_fill_last", 3'd1, 1, 0, 1, 0, 0);
      exp_at(16, "t5_settle",    3'd2, 0, 0, 1, 0, 0);
      exp_at(19, "t5_settle_e",  3'd2, 0, 0, 1, 0, 0);
      exp_at(20, "t5_done",      3'd3, 0, 0, 0, 1, 0);
      exp_at(21, "t5_idle",      3'd0, 0, 0, 0, 0, 0);
      step(4);
      nivel = 1'b1;
      step(1);
      nivel = 1'b0;
      step(6);
      nivel = 1'b1;
      step(10);
      nivel = 1'b0;
      step(4);

      // abort and start together in idle
      abort  = 1'b1;
      start  = 1'b1;
      estado = 2'b01;
      t0     = cyc + 1;
      exp_at(0, "t6_abort_start", 3'd0, 0, 0, 0, 0, 0);
      exp_at(1, "t6_still_idle",  3'd0, 0, 0, 0, 0, 0);
      step(1);
      abort = 1'b0;
      start = 1'b0;
      step(2);

      // level already high at start, then abort during settle
      start_fill(2'b01);
      nivel = 1'b1;
      exp_at(0, "t6_full_fill",   3'd1, 1, 0, 1, 0, 0);
      exp_at(4, "t6_full_last",   3'd1, 1, 0, 1, 0, 0);
      exp_at(5, "t6_full_settle", 3'd2, 0, 0, 1, 0, 0);
      exp_at(6, "t6_settle_hold", 3'd2, 0, 0, 1, 0, 0);
      exp_at(7, "t6_abort_settl", 3'd0, 0, 0, 0, 0, 0);
      exp_at(9, "t6_no_done",     3'd0, 0, 0, 0, 0, 0);
      step(6);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      nivel = 1'b0;
      step(4);

      // asynchronous reset in the middle of a fill
      start_fill(2'b11);
      exp_at(0, "t6c_fill",   3'd1, 0, 1, 1, 0, 0);
      exp_at(2, "t6c_fill_b", 3'd1, 0, 1, 1, 0, 0);
      step(3);
      rst_n = 1'b0;
      exp_at(3, "t6c_reset_now", 3'd0, 0, 0, 0, 0, 0);
      step(1);
      rst_n = 1'b1;
      exp_at(5, "t6c_idle",    3'd0, 0, 0, 0, 0, 0);
      exp_at(8, "t6c_no_done", 3'd0, 0, 0, 0, 0, 0);
      step(10);

      for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d expectations left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
